// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among several byte
// producers. It accepts one byte in IDLE, issues a single start pulse, then
// follows the transmitter's ready/busy status until the frame completes. A
// watchdog abandons a transfer that the transmitter never picks up.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          uart_start,
  output logic [DATA_W-1:0]             uart_data,
  input  logic                          uart_ready,
  input  logic                          uart_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      ptr_d;
  logic [CNTW-1:0]     cnt_q;
  logic                uart_start_q;
  logic [DATA_W-1:0]   uart_data_q;
  logic [IDW-1:0]      grant_id_q;
  logic                active_q;
  logic                timeout_err_q;

  logic                win_found;
  logic [IDW-1:0]      win_idx;
  logic [DATA_W-1:0]   win_data;
  logic                grant_en;

  // Find the first valid requester at or above the pointer, then wrap to the bottom.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (i >= int'(ptr_q))) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end

  // Accept only from IDLE with an idle transmitter; also select the winner's byte and the next pointer.
  always_comb begin
    grant_en  = (state_q == IDLE) && win_found && uart_ready && !uart_busy && !rst;
    req_ready = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_data = req_data[i*DATA_W +: DATA_W];
        if (grant_en) begin
          req_ready[i] = 1'b1;
        end
      end
    end
    if (win_idx == IDW'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx + 1'b1;
    end
  end

  // Sequencer: accept, one-cycle start pulse, wait for pickup (with watchdog), wait for completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      uart_start_q  <= 1'b0;
      uart_data_q   <= '0;
      grant_id_q    <= '0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      uart_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            uart_data_q  <= win_data;
            grant_id_q   <= win_idx;
            ptr_q        <= ptr_d;
            active_q     <= 1'b1;
            uart_start_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_busy || !uart_ready) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNTW'(START_TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            active_q      <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (uart_ready && !uart_busy) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign uart_start  = uart_start_q;
  assign uart_data   = uart_data_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single transfer, round-robin order,
// fairness after a grant, watchdog abort, busy-beats-watchdog, busy gating
// and asynchronous reset during the start pulse.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 12;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              uart_start;
  logic [DW-1:0]     uart_data;
  logic              uart_ready;
  logic              uart_busy;
  logic [1:0]        grant_id;
  logic              active;
  logic              timeout_err;

  int checks;
  int errors;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ),
    .DATA_W(DW),
    .START_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .uart_start(uart_start),
    .uart_data(uart_data),
    .uart_ready(uart_ready),
    .uart_busy(uart_busy),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*DW-1:0] data);
    req_valid = valid;
    req_data  = data;
    #1;
  endtask

  // Called during the ISSUE cycle: transmitter goes busy for busyCycles, then frees up.
  task automatic transmit(input int busyCycles, input string tag);
    uart_busy  = 1'b1;
    uart_ready = 1'b0;
    for (int i = 0; i < busyCycles; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput({tag, "_start_off"}, 32'(uart_start), 32'd0);
    end
    checkOutput({tag, "_active_busy"}, 32'(active), 32'd1);
    checkOutput({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
    uart_busy  = 1'b0;
    uart_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_active_done"}, 32'(active), 32'd0);
  endtask

  logic [NREQ*DW-1:0] dataB;
  int expIdx;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    uart_ready = 1'b1;
    uart_busy  = 1'b0;
    dataB      = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_start", 32'(uart_start), 32'd0);
    checkOutput("rst_data", 32'(uart_data), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 0
    applyStimulus(4'b0001, {24'h0, 8'h5A});
    checkOutput("t1_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    checkOutput("t1_start", 32'(uart_start), 32'd1);
    checkOutput("t1_data", 32'(uart_data), 32'h5A);
    checkOutput("t1_grant", 32'(grant_id), 32'd0);
    checkOutput("t1_active", 32'(active), 32'd1);
    checkOutput("t1_ready_issue", 32'(req_ready), 32'd0);
    applyStimulus(4'b0000, {24'h0, 8'h5A});
    transmit(10, "t1");
    checkOutput("t1_data_hold", 32'(uart_data), 32'h5A);
    checkOutput("t1_grant_hold", 32'(grant_id), 32'd0);

    // Short reset pulse returns the pointer to requester 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst2_data", 32'(uart_data), 32'd0);

    // All four requesters valid: grants 0,1,2,3,0 with matching bytes
    applyStimulus(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
    for (int g = 0; g < 5; g++) begin
      expIdx = g % 4;
      checkOutput("t2_ready", 32'(req_ready), 32'(1 << expIdx));
      @(negedge clk);
      checkOutput("t2_start", 32'(uart_start), 32'd1);
      checkOutput("t2_grant", 32'(grant_id), 32'(expIdx));
      checkOutput("t2_data", 32'(uart_data), 32'(8'h10 + expIdx));
      transmit(10, "t2");
    end
    applyStimulus(4'b0000, dataB);

    // Fairness: grant 2 alone, then 0 and 3 together -> 3 before 0
    applyStimulus(4'b0100, dataB);
    checkOutput("t3_ready2", 32'(req_ready), 32'h4);
    @(negedge clk);
    checkOutput("t3_data2", 32'(uart_data), 32'hC2);
    applyStimulus(4'b1001, dataB);
    transmit(2, "t3a");
    checkOutput("t3_ready3", 32'(req_ready), 32'h8);
    @(negedge clk);
    checkOutput("t3_grant3", 32'(grant_id), 32'd3);
    checkOutput("t3_data3", 32'(uart_data), 32'hD3);
    transmit(2, "t3b");
    checkOutput("t3_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    checkOutput("t3_grant0", 32'(grant_id), 32'd0);
    applyStimulus(4'b0000, dataB);
    transmit(2, "t3c");

    // Watchdog: requester 1 granted, transmitter never picks up
    applyStimulus(4'b0010, dataB);
    checkOutput("t4_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    checkOutput("t4_start", 32'(uart_start), 32'd1);
    checkOutput("t4_grant", 32'(grant_id), 32'd1);
    applyStimulus(4'b0000, dataB);
    repeat (TIMEOUT) begin
      @(negedge clk);
      checkOutput("t4_wait_timeout", 32'(timeout_err), 32'd0);
      checkOutput("t4_wait_active", 32'(active), 32'd1);
    end
    @(negedge clk);
    checkOutput("t4_timeout_pulse", 32'(timeout_err), 32'd1);
    checkOutput("t4_active_off", 32'(active), 32'd0);
    @(negedge clk);
    checkOutput("t4_timeout_clear", 32'(timeout_err), 32'd0);
    applyStimulus(4'b0011, dataB);
    checkOutput("t4_ptr_advanced", 32'(req_ready), 32'h1);
    applyStimulus(4'b0000, dataB);
    @(negedge clk);
    checkOutput("t4_drop_active", 32'(active), 32'd0);

    // Busy rises in the last watchdog cycle: busy wins, no timeout
    applyStimulus(4'b0100, dataB);
    checkOutput("tw_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    checkOutput("tw_grant", 32'(grant_id), 32'd2);
    applyStimulus(4'b0000, dataB);
    repeat (TIMEOUT) @(negedge clk);
    checkOutput("tw_still_waiting", 32'(active), 32'd1);
    uart_busy  = 1'b1;
    uart_ready = 1'b0;
    @(negedge clk);
    checkOutput("tw_no_timeout", 32'(timeout_err), 32'd0);
    checkOutput("tw_active", 32'(active), 32'd1);
    uart_busy  = 1'b0;
    uart_ready = 1'b1;
    @(negedge clk);
    checkOutput("tw_done", 32'(active), 32'd0);
    checkOutput("tw_no_timeout2", 32'(timeout_err), 32'd0);

    // Busy held: nothing accepted until busy falls with ready high
    uart_busy = 1'b1;
    applyStimulus(4'b1111, dataB);
    checkOutput("t5_ready_busy", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t5_ready_busy_hold", 32'(req_ready), 32'd0);
    checkOutput("t5_active_busy", 32'(active), 32'd0);
    uart_busy  = 1'b0;
    uart_ready = 1'b0;
    #1;
    checkOutput("t5_ready_notready", 32'(req_ready), 32'd0);
    @(negedge clk);
    uart_ready = 1'b1;
    #1;
    checkOutput("t5_ready_free", 32'(req_ready), 32'h8);
    @(negedge clk);
    checkOutput("t5_start", 32'(uart_start), 32'd1);
    checkOutput("t5_grant", 32'(grant_id), 32'd3);
    checkOutput("t5_data", 32'(uart_data), 32'hD3);
    applyStimulus(4'b0000, dataB);
    transmit(3, "t5");

    // Reset during ISSUE drops outputs at once and restores requester 0 priority
    applyStimulus(4'b0010, dataB);
    checkOutput("t6_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    checkOutput("t6_start_pre", 32'(uart_start), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_start_rst", 32'(uart_start), 32'd0);
    checkOutput("t6_active_rst", 32'(active), 32'd0);
    checkOutput("t6_ready_rst", 32'(req_ready), 32'd0);
    checkOutput("t6_data_rst", 32'(uart_data), 32'd0);
    checkOutput("t6_grant_rst", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1111, dataB);
    checkOutput("t6_ptr_reset", 32'(req_ready), 32'h1);
    applyStimulus(4'b0000, dataB);
    @(negedge clk);
    checkOutput("t6_idle_after", 32'(active), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
